// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for the CompactRISC16 core. It owns the program
// counter and issues single-word reads to instruction memory. The returned
// instruction and its address are latched and offered to decode with a
// valid/ready handshake. Execute can redirect the PC at any time.
//
// Optional feature (define FETCH_PERF_COUNT_EN to enable):
//   O_FETCH_COUNT - saturating 32-bit count of completed decode handshakes.
//
// Ports:
//   I_CLK            clock, all state changes on the rising edge
//   I_NRESET         synchronous active-low reset
//   I_ENABLE         run enable, gates the start of new fetches
//   O_MEM_ADDR       instruction memory word address (current PC)
//   O_MEM_REQ        memory read request
//   I_MEM_DATA       memory read data
//   I_MEM_VALID      read data valid, only meaningful while O_MEM_REQ=1
//   I_REDIRECT       branch/jump taken, one-cycle pulse
//   I_REDIRECT_ADDR  redirect target
//   O_INSTR          fetched instruction
//   O_PC             address of O_INSTR
//   O_VALID          O_INSTR/O_PC valid
//   I_READY          decode accepts this cycle
//   O_FETCH_COUNT    (FETCH_PERF_COUNT_EN only) completed handshakes
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned                 P_ADDR_WIDTH = 16,
  parameter int unsigned                 P_DATA_WIDTH = 16,
  parameter logic [P_ADDR_WIDTH-1:0]     P_RESET_PC   = '0
) (
  input  logic                    I_CLK,
  input  logic                    I_NRESET,
  input  logic                    I_ENABLE,
  output logic [P_ADDR_WIDTH-1:0] O_MEM_ADDR,
  output logic                    O_MEM_REQ,
  input  logic [P_DATA_WIDTH-1:0] I_MEM_DATA,
  input  logic                    I_MEM_VALID,
  input  logic                    I_REDIRECT,
  input  logic [P_ADDR_WIDTH-1:0] I_REDIRECT_ADDR,
  output logic [P_DATA_WIDTH-1:0] O_INSTR,
  output logic [P_ADDR_WIDTH-1:0] O_PC,
  output logic                    O_VALID,
  input  logic                    I_READY
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]             O_FETCH_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_e;

  state_e                  state_q, state_d;
  logic [P_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [P_DATA_WIDTH-1:0] instr_q, instr_d;
  logic [P_ADDR_WIDTH-1:0] opc_q, opc_d;

  // Next-state logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    opc_d   = opc_q;

    unique case (state_q)
      S_IDLE: begin
        if (I_ENABLE) state_d = S_FETCH;
      end
      S_FETCH: begin
        // Enable is not consulted here: an issued read always completes.
        if (I_MEM_VALID) begin
          instr_d = I_MEM_DATA;
          opc_d   = pc_q;
          pc_d    = pc_q + P_ADDR_WIDTH'(1);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (I_READY) state_d = I_ENABLE ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect wins over the normal flow. Data returning in the same cycle is
    // discarded, and an unaccepted instruction in S_HOLD is dropped. An
    // abandoned read passes through S_IDLE so the request drops for a cycle
    // before the new address is presented; from S_IDLE or S_HOLD the new
    // request goes out on the very next cycle.
    if (I_REDIRECT) begin
      pc_d    = I_REDIRECT_ADDR;
      instr_d = instr_q;
      opc_d   = opc_q;
      if (state_q == S_FETCH) state_d = S_IDLE;
      else                    state_d = I_ENABLE ? S_FETCH : S_IDLE;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge I_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!I_NRESET) begin
      state_q <= S_IDLE;
      pc_q    <= P_RESET_PC;
      instr_q <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  // Handshake outputs are decoded from state only; the address is the PC,
  // which does not move while a request is outstanding.
  assign O_MEM_REQ  = (state_q == S_FETCH);
  assign O_VALID    = (state_q == S_HOLD);
  assign O_MEM_ADDR = pc_q;
  assign O_INSTR    = instr_q;
  assign O_PC       = opc_q;

`ifdef FETCH_PERF_COUNT_EN
  logic        handshake;
  logic [31:0] count_q;

  // A redirect coinciding with I_READY still completes the handshake, so it
  // counts; a redirect-dropped instruction never sees I_READY and does not.
  assign handshake = (state_q == S_HOLD) && I_READY;

  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      count_q <= '0;
    end else if (handshake && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign O_FETCH_COUNT = count_q;
`endif

endmodule
